// File: rtl/hps_system_buttons.sv
// Avalon-MM push-button input PIO: synchronizer, per-bit debouncer, press-edge capture and masked level irq.
// Build option: define HPS_SYSTEM_BUTTONS_DEBOUNCE_EN to include the debounce counters; otherwise deb follows sync2.
module hps_system_buttons #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] deb_r;
    logic [WIDTH-1:0] deb_next_s;
    logic [WIDTH-1:0] edgecap_r;
    logic [WIDTH-1:0] edgecap_next_s;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] mask_next_s;
    logic             wr_s;
    logic [31:0]      rd_s;
    logic             unused_s;

    assign wr_s     = chipselect & ~write_n;
    assign unused_s = ^writedata;

    // Two-flop synchronizer for the asynchronous button levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= {WIDTH{1'b1}};
            sync2_r <= {WIDTH{1'b1}};
        end else begin
            sync1_r <= in_port;
            sync2_r <= sync1_r;
        end
    end

`ifdef HPS_SYSTEM_BUTTONS_DEBOUNCE_EN
    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [CNT_W-1:0] cnt_r      [WIDTH];
    logic [CNT_W-1:0] cnt_next_s [WIDTH];

    // Per-bit stability counter; deb flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        deb_next_s = deb_r;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next_s[i] = CNT_ZERO;
            if (sync2_r[i] == deb_r[i]) begin
                cnt_next_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_MAX) begin
                deb_next_s[i] = sync2_r[i];
                cnt_next_s[i] = CNT_ZERO;
            end else begin
                cnt_next_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Debounce counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end
`else
    localparam int unused_debounce_cycles_p = DEBOUNCE_CYCLES;

    // Without debouncing the state simply tracks the synchronized input
    always_comb begin
        deb_next_s = sync2_r;
    end
`endif

    // Edge capture: write-1-to-clear, with a same-cycle press edge taking priority over the clear
    always_comb begin
        edgecap_next_s = edgecap_r;
        if (wr_s && (address == 2'd3)) begin
            edgecap_next_s = edgecap_r & ~writedata[WIDTH-1:0];
        end else begin
            edgecap_next_s = edgecap_r;
        end
        edgecap_next_s = edgecap_next_s | (deb_r & ~deb_next_s);
    end

    // Interrupt mask write decode
    always_comb begin
        mask_next_s = mask_r;
        if (wr_s && (address == 2'd2)) begin
            mask_next_s = writedata[WIDTH-1:0];
        end else begin
            mask_next_s = mask_r;
        end
    end

    // Debounced state, edge capture and mask registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_r     <= {WIDTH{1'b1}};
            edgecap_r <= {WIDTH{1'b0}};
            mask_r    <= {WIDTH{1'b0}};
        end else begin
            deb_r     <= deb_next_s;
            edgecap_r <= edgecap_next_s;
            mask_r    <= mask_next_s;
        end
    end

    // Zero-wait-state read mux, zero-extended above WIDTH
    always_comb begin
        rd_s = 32'h0000_0000;
        case (address)
            2'd0:    rd_s[WIDTH-1:0] = deb_r;
            2'd2:    rd_s[WIDTH-1:0] = mask_r;
            2'd3:    rd_s[WIDTH-1:0] = edgecap_r;
            default: rd_s = 32'h0000_0000;
        endcase
    end

    assign readdata = rd_s;
    assign irq      = |(edgecap_r & mask_r);

endmodule

// File: tb/tb_hps_system_buttons.sv
// Scoreboard bench for hps_system_buttons: directed plan sequences plus randomized traffic against a window-based model.
module tb_hps_system_buttons;
    localparam int W = 4;
    localparam int D = 4;
`ifdef HPS_SYSTEM_BUTTONS_DEBOUNCE_EN
    localparam int D_EFF = D;
`else
    localparam int D_EFF = 1;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [W-1:0] in_port;
    logic [31:0]  readdata;
    logic         irq;

    always #5 clk = ~clk;

    hps_system_buttons #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: sampling pipe, window of last D_EFF samples, debounced state, registers
    logic [W-1:0] m_s1, m_s2, m_deb, m_ec, m_mask;
    logic [W-1:0] m_win[$];

    task automatic m_reset();
        m_s1 = '1; m_s2 = '1; m_deb = '1; m_ec = '0; m_mask = '0;
        m_win.delete();
    endtask

    // A bit flips once the last D_EFF samples it saw all disagree with its current state
    task automatic m_clock();
        logic [W-1:0] s, flip, nd;
        s = m_s2; m_s2 = m_s1; m_s1 = in_port;
        m_win.push_back(s);
        if (m_win.size() > D_EFF) void'(m_win.pop_front());
        flip = '0;
        if (m_win.size() == D_EFF) begin
            flip = '1;
            foreach (m_win[j]) flip &= (m_win[j] ^ m_deb);
        end
        nd = m_deb ^ flip;
        if (chipselect && !write_n) begin
            if (address == 2'd2) m_mask = writedata[W-1:0];
            if (address == 2'd3) m_ec = m_ec & ~writedata[W-1:0];
        end
        m_ec = m_ec | (m_deb & ~nd);
        m_deb = nd;
    endtask

    function automatic exp_t expected();
        exp_t e;
        e.rd = 32'h0;
        case (address)
            2'd0:    e.rd[W-1:0] = m_deb;
            2'd2:    e.rd[W-1:0] = m_mask;
            2'd3:    e.rd[W-1:0] = m_ec;
            default: e.rd = 32'h0;
        endcase
        e.irq = |(m_ec & m_mask);
        return e;
    endfunction

    task automatic cycle(input logic rn, input logic [1:0] a, input logic cs, input logic wn,
                         input logic [31:0] wd, input logic [W-1:0] inp);
        @(posedge clk);
        #1;
        if (reset_n) m_clock();
        reset_n = rn; address = a; chipselect = cs; write_n = wn; writedata = wd; in_port = inp;
        if (!rn) m_reset();
        exp_q.push_back(expected());
    endtask

    task automatic idle(input int n, input logic [1:0] a, input logic [W-1:0] inp);
        for (int i = 0; i < n; i++) cycle(1'b1, a, 1'b0, 1'b1, 32'h0, inp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [W-1:0] inp);
        cycle(1'b1, a, 1'b1, 1'b0, d, inp);
    endtask

    // Monitor: compare every queued expectation against the DUT on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (readdata !== e.rd) begin
                    errors++;
                    $display("FAIL readdata addr=%0d: got %h expected %h at %0t", address, readdata, e.rd, $time);
                end
                checks++;
                if (irq !== e.irq) begin
                    errors++;
                    $display("FAIL irq: got %b expected %b at %0t", irq, e.irq, $time);
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'h0; in_port = 4'hF;
        m_reset();

        // Reset state
        cycle(1'b0, 2'd0, 1'b0, 1'b1, 32'h0, 4'hF);
        cycle(1'b0, 2'd3, 1'b0, 1'b1, 32'h0, 4'hF);
        cycle(1'b0, 2'd1, 1'b0, 1'b1, 32'h0, 4'hF);
        idle(2, 2'd0, 4'hF);

        // Clean press, clear, release
        wr(2'd2, 32'h1, 4'hF);
        idle(1, 2'd0, 4'hE);
        idle(6, 2'd3, 4'hE);
        wr(2'd3, 32'h1, 4'hE);
        idle(2, 2'd3, 4'hE);
        idle(8, 2'd3, 4'hF);

        // Glitch rejection then a real press on bit 2
        idle(3, 2'd0, 4'hB);
        idle(6, 2'd3, 4'hF);
        idle(8, 2'd3, 4'hB);
        wr(2'd3, 32'hF, 4'hF);
        idle(7, 2'd0, 4'hF);

        // Masking
        wr(2'd2, 32'h0, 4'h5);
        idle(7, 2'd3, 4'h5);
        wr(2'd2, 32'h8, 4'h5);
        wr(2'd3, 32'h8, 4'h5);
        idle(2, 2'd3, 4'h5);
        wr(2'd3, 32'hF, 4'hF);
        idle(7, 2'd0, 4'hF);

        // Clear on the same edge deb[0] falls
        wr(2'd2, 32'h1, 4'hE);
        idle(4, 2'd0, 4'hE);
        wr(2'd3, 32'h1, 4'hE);
        idle(3, 2'd3, 4'hE);
        wr(2'd3, 32'hF, 4'hF);
        idle(7, 2'd0, 4'hF);

        // Reset mid-count with bit 0 held low
        idle(3, 2'd0, 4'hE);
        cycle(1'b0, 2'd0, 1'b0, 1'b1, 32'h0, 4'hE);
        cycle(1'b0, 2'd3, 1'b0, 1'b1, 32'h0, 4'hE);
        idle(8, 2'd0, 4'hE);
        idle(8, 2'd3, 4'hF);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            logic [W-1:0] inp;
            int hold;
            inp  = W'($urandom);
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                cycle(($urandom_range(0, 199) != 0), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                      $urandom, inp);
            end
        end

        idle(2, 2'd0, 4'hF);
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hps_system_buttons.md
# hps_system_buttons

Avalon-MM slave input PIO for the push-buttons on the HPS lightweight bridge, the read-side counterpart of the LED output PIO. Each active-low button input goes through a two-flop synchronizer and a per-bit debouncer. Press (falling) edges are latched in a write-1-to-clear edge-capture register. A level interrupt is raised to the HPS when any captured, unmasked edge is pending.

## Interface
Parameters:
- WIDTH, 4: number of button inputs (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive stable clocks required before a debounced bit changes (≥2). Counter width is $clog2(DEBOUNCE_CYCLES).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word address: 0 data, 2 interruptmask, 3 edgecapture; 1 reserved.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits [WIDTH-1:0] used.
- in_port  in  WIDTH  raw button levels, asynchronous, active-low (1 = released).
- readdata  out  32  read data, zero-extended above WIDTH.
- irq  out  1  level interrupt request.

## Operation
- Synchronizer: sync1 <= in_port; sync2 <= sync1. Both reset to all ones.
- Debouncer, per bit i, with counter cnt[i] and state deb[i] (reset 1):
  - If sync2[i] == deb[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: deb[i] <= sync2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES clears the count and never reaches deb.
- Edge capture: on the clock where deb[i] goes 1→0, edgecapture[i] <= 1. Release (0→1) never sets a bit.
- Write address 3: bits written 1 are cleared, bits written 0 are unchanged. If a clear and a new press edge hit the same bit in the same cycle, the edge wins and the bit stays 1.
- Write address 2: interruptmask <= writedata[WIDTH-1:0].
- Writes to addresses 0 and 1 are ignored.
- Read mux (combinational, zero wait states, read latency 0):
  - 0 → deb
  - 1 → 0
  - 2 → interruptmask
  - 3 → edgecapture
- irq = |(edgecapture & interruptmask), combinational from registers.
- Reset values: sync1, sync2, deb = all ones; cnt, edgecapture, interruptmask = 0; irq = 0; readdata = {0, all ones} at address 0, 0 at other addresses.
- Reset asserted mid-debounce or with edges pending clears all state immediately. No edge is captured on reset release while buttons are held: deb starts at 1, so a held button produces one edge after DEBOUNCE_CYCLES, which is intended.

## Timing
- in_port change sampled at clock edge k: sync2 reflects it at edge k+1.
- If stable from then, deb changes at edge k+1+DEBOUNCE_CYCLES. edgecapture sets on the same edge. irq rises combinationally after that edge when masked in.
- Register writes take effect on the clock edge where chipselect & ~write_n. irq follows on the same edge.
- readdata is valid in the same cycle as address; no pipeline.

## Configuration
- HPS_SYSTEM_BUTTONS_DEBOUNCE_EN
  - Defined: debouncer present as described.
  - Undefined: counters removed; deb <= sync2 every clock. Edge capture then happens 2 clocks after the sampling edge. DEBOUNCE_CYCLES is ignored. Register map, reset values and irq rules are unchanged.

## Test plan
Bench uses WIDTH=4, DEBOUNCE_CYCLES=4, macro defined unless noted.
- Reset: hold reset_n=0, in_port=4'hF → readdata at address 0 = 0x0000000F, address 3 = 0, irq=0. Assert reset mid-count with bit 0 low → deb stays 0xF after release until 4 fresh stable cycles.
- Clean press: mask=0x1, drive in_port=4'hE at edge k → deb=0xE and edgecapture=0x1 at edge k+5, irq=1. Write 0x1 to address 3 → edgecapture=0, irq=0. Release → no new capture.
- Glitch rejection: bit 2 low for 3 clocks, then high → deb stays 0xF, edgecapture=0. Low for 4+ stable clocks → edgecapture=0x4.
- Masking: press bits 1 and 3 with mask=0 → edgecapture=0xA, irq=0. Write mask=0x8 → irq=1. Clear 0x8 → irq=0 while edgecapture=0x2.
- Simultaneous clear and edge: write 0x1 to address 3 on the exact edge deb[0] falls → edgecapture[0] remains 1.
- Macro undefined: in_port=4'h7 at edge k → deb=0x7 and edgecapture=0x8 at edge k+2. A 1-clock glitch is captured as an edge.
